// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants and slave state encoding
package spi_pkg;

  // Fixed frame layout: ID byte, address byte, data byte.
  localparam int FRAME_BITS = 24;
  localparam int BYTE_BITS  = 8;

  // Default ID bytes, shared with the master side of the link.
  localparam logic [7:0] SLAVE_IDW_DEF = 8'hFF;
  localparam logic [7:0] SLAVE_IDR_DEF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_ADDR_W,
    ST_DATA_W,
    ST_ADDR_R,
    ST_DATA_R,
    ST_TAIL,
    ST_IGNORE
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-stage input synchroniser with edge pulses
module spi_sync
  import spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  // Shift the pin through the chain; keep the previous synced sample for edge detection.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_chain <= {STAGES{RESET_VAL}};
      r_prev  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_q    = r_chain[STAGES-1];
  assign o_rise = r_chain[STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling mode-0 SPI slave decoding ID/addr/data frames
module spi_slave
  import spi_pkg::*;
#(
  parameter logic [7:0] SLAVE_IDW   = SLAVE_IDW_DEF,
  parameter logic [7:0] SLAVE_IDR   = SLAVE_IDR_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_sclk,
  input  logic       i_ss,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_rd_en,
  output logic [7:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_busy,
  output logic       o_frame_err
);

  localparam logic [4:0] C_ID_END   = 5'(BYTE_BITS);
  localparam logic [4:0] C_ADDR_END = 5'(2 * BYTE_BITS);
  localparam logic [4:0] C_DATA_END = 5'(FRAME_BITS);
  localparam logic [3:0] C_TX_BITS  = 4'(BYTE_BITS);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_ss_q, w_ss_rise, w_ss_fall;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;
  logic w_unused_sync;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clock(i_clock), .i_reset(i_reset), .i_d(i_sclk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .i_clock(i_clock), .i_reset(i_reset), .i_d(i_ss),
    .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clock(i_clock), .i_reset(i_reset), .i_d(i_mosi),
    .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused_sync = ^{w_sclk_q, w_ss_q, w_mosi_rise, w_mosi_fall};

  spi_state_e r_state;
  logic [4:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_addr;
  logic [7:0] r_tx;
  logic [3:0] r_tx_cnt;
  logic       r_load;
  logic       r_miso, r_wr_en, r_rd_en, r_busy, r_frame_err;
  logic [7:0] r_wr_addr, r_wr_data, r_rd_addr;

  logic [4:0] w_cnt_next;
  logic [7:0] w_byte;
  logic       w_rise_at;

  // Count and byte value as they will be once the current sclk rise is taken.
  assign w_cnt_next = r_bit_cnt + 5'd1;
  assign w_byte     = {r_shift[6:0], w_mosi_q};
  assign w_rise_at  = w_sclk_rise;

  // Frame decoder: bit capture, state sequencing, strobes and miso shifting.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_tx        <= '0;
      r_tx_cnt    <= '0;
      r_load      <= 1'b0;
      r_miso      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= 1'b0;
      // Local data arrives the cycle after the read request.
      r_load      <= r_rd_en;

      if (w_rise_at) begin
        r_shift   <= w_byte;
        r_bit_cnt <= w_cnt_next;
      end
      if (w_ss_fall) begin
        r_bit_cnt <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          if (w_ss_fall) begin
            r_state <= ST_ID;
            r_busy  <= 1'b1;
          end
        end

        ST_ID, ST_ADDR_W, ST_ADDR_R: begin
          r_miso <= 1'b0;
          if (w_ss_rise) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
          end else if (w_rise_at && r_state == ST_ID && w_cnt_next == C_ID_END) begin
            if (w_byte == SLAVE_IDW) begin
              r_state <= ST_ADDR_W;
            end else if (w_byte == SLAVE_IDR) begin
              r_state <= ST_ADDR_R;
            end else begin
              r_state     <= ST_IGNORE;
              r_frame_err <= 1'b1;
            end
          end else if (w_rise_at && w_cnt_next == C_ADDR_END) begin
            if (r_state == ST_ADDR_W) begin
              r_addr  <= w_byte;
              r_state <= ST_DATA_W;
            end else if (r_state == ST_ADDR_R) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_byte;
              r_tx_cnt  <= '0;
              r_state   <= ST_DATA_R;
            end
          end
        end

        ST_DATA_W: begin
          r_miso <= 1'b0;
          // A last rise seen together with ss rise still completes the write.
          if (w_rise_at && w_cnt_next == C_DATA_END) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= w_byte;
            r_state   <= w_ss_rise ? ST_IDLE : ST_TAIL;
            r_busy    <= ~w_ss_rise;
          end else if (w_ss_rise) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
          end
        end

        ST_DATA_R: begin
          if (w_rise_at && w_cnt_next == C_DATA_END) begin
            r_miso  <= 1'b0;
            r_state <= w_ss_rise ? ST_IDLE : ST_TAIL;
            r_busy  <= ~w_ss_rise;
          end else if (w_ss_rise) begin
            r_miso      <= 1'b0;
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
          end else begin
            if (r_load) begin
              r_tx <= i_rd_data;
            end
            if (w_sclk_fall) begin
              if (r_tx_cnt < C_TX_BITS) begin
                r_miso   <= r_tx[7];
                r_tx     <= {r_tx[6:0], 1'b0};
                r_tx_cnt <= r_tx_cnt + 4'd1;
              end else begin
                r_miso <= 1'b0;
              end
            end
          end
        end

        ST_TAIL, ST_IGNORE: begin
          r_miso <= 1'b0;
          if (w_ss_rise) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_miso  <= 1'b0;
        end
      endcase
    end
  end

  assign o_miso      = r_miso;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_rd_addr;
  assign o_busy      = r_busy;
  assign o_frame_err = r_frame_err;

endmodule
